ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single-port synchronous RAM (clk, we, rwaddr, di, do) between port A and port B.
- Issues at most one RAM access per cycle and routes read data back to the requester that issued the read.
- Keeps a saturating count of contention cycles for debug.
- Sits between two client engines and the ram instance.

Parameters:
- AW, 6, address width (matches RAM rwaddr)
- DW, 16, data width (matches RAM di/do)
- CW, 16, width of contention counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- a_req  input  1  port A access request; held with a_we/a_addr/a_di until a_gnt
- a_we  input  1  port A write enable (1 = write, 0 = read)
- a_addr  input  AW  port A address
- a_di  input  DW  port A write data
- a_gnt  output  1  port A request accepted this cycle (combinational)
- a_rvalid  output  1  port A read data valid (one-cycle pulse)
- a_do  output  DW  port A read data, held until next A read response
- b_req, b_we, b_addr, b_di, b_gnt, b_rvalid, b_do  same as port A, for port B
- ram_we  output  1  to RAM we
- ram_rwaddr  output  AW  to RAM rwaddr
- ram_di  output  DW  to RAM di
- ram_do  input  DW  from RAM do
- conflict_cnt  output  CW  saturating count of cycles with a_req and b_req both high

Behaviour:
- RAM contract:
  - RAM samples we/rwaddr/di on the rising clk edge.
  - A write takes effect at that edge.
  - Read data appears on ram_do one cycle after the address is sampled.
  - Write-then-read of the same address in consecutive cycles returns the new data.
- Reset (rst_n=0, async):
  - a_gnt=b_gnt=0, ram_we=0, ram_rwaddr=0, ram_di=0.
  - a_rvalid=b_rvalid=0, a_do=b_do=0, conflict_cnt=0.
  - last_owner=B, so A wins the first tie.
  - Any in-flight read response is discarded.
- Grant (combinational, gated by rst_n):
  - a_gnt = a_req & (~b_req | last_owner==B).
  - b_gnt = b_req & (~a_req | last_owner==A).
  - Never both high.
  - A lone requester is granted every cycle, back-to-back.
- RAM drive:
  - Granted port's we/addr/di are muxed to ram_we/ram_rwaddr/ram_di in the same cycle.
  - No grant: ram_we=0, ram_rwaddr=0, ram_di=0.
- last_owner register:
  - Updates at the clock edge to the granted port.
  - Unchanged when idle.
  - Contention therefore alternates A,B,A,B.
- Read pipeline:
  - Read grant (gnt & ~we) sets register rd_pend_a or rd_pend_b at the edge.
  - In the following cycle the pending port sees rvalid=1.
  - Its xx_do captures ram_do at the end of that cycle (register, visible from the next edge).
  - Requirement: rvalid and a valid xx_do are visible in the same cycle. Implement by driving xx_do = ram_do combinationally while rd_pend is set, otherwise the held capture register.
  - Write grants produce no rvalid.
  - The non-selected port's xx_do is unaffected.
- Throughput:
  - One access per cycle.
  - Back-to-back reads from alternating ports yield alternating rvalid pulses, each one cycle after its grant.
- conflict_cnt:
  - +1 on each edge where a_req&b_req.
  - Saturates at all-ones; never wraps.
- Requester rules:
  - Request fields must stay stable while req=1 and gnt=0.
  - Dropping req before gnt is legal (request withdrawn, no access).
  - A granted request may be followed immediately by a new one (req held high with new fields).

Test Plan:
- Reset, A writes 0x2A=0xCAFE (1 cycle), A reads 0x2A:
  - a_gnt same cycle both times.
  - ram_we=1 only on the write.
  - a_rvalid=1 exactly one cycle after read grant, a_do=0xCAFE, held afterwards.
- Same cycle, A write 0x3A=0xDEED and B read 0x3A, both held:
  - Cycle0 a_gnt (tie, last_owner=B); cycle1 b_gnt; cycle2 b_rvalid with b_do=0xDEED.
  - conflict_cnt=1.
- a_req and b_req both held high for 6 cycles, reads of 0x01 (A) / 0x02 (B) preloaded 0x1111/0x2222:
  - Grants alternate A,B,A,B,A,B.
  - rvalids alternate with the correct data.
  - conflict_cnt=6.
- Only B requests reads for 4 consecutive cycles at 0x00..0x03:
  - b_gnt every cycle.
  - 4 consecutive b_rvalid pulses in order.
  - a_* outputs unchanged; conflict_cnt=0.
- Reset pulse asserted in the cycle after an A read grant:
  - a_rvalid stays 0, a_do=0, conflict_cnt=0.
  - After release, the next tie goes to A.
- Force conflict_cnt with CW=4: hold both requests 20 cycles -> count stops at 0xF, no wrap.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Two-requester round-robin arbiter that shares one single-port synchronous
//   RAM between client ports A and B. At most one RAM access is issued per
//   cycle. Read data returns to the port that issued the read, one cycle after
//   the grant. A saturating counter tracks the cycles in which both ports
//   request at once.
//
// Ports
//   clk, rst_n               : rising-edge clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_di   : port A request; fields held until a_gnt
//   a_gnt                    : port A request accepted this cycle (combinational)
//   a_rvalid, a_do           : port A read response pulse and read data
//   b_*                      : same set of signals for port B
//   ram_we/ram_rwaddr/ram_di : command to the RAM
//   ram_do                   : read data from the RAM (one cycle after address)
//   conflict_cnt             : saturating count of cycles with both requests high
module ram_arbiter #(
  parameter int AW = 6,
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_di,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_do,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_di,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_do,
  output logic          ram_we,
  output logic [AW-1:0] ram_rwaddr,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do,
  output logic [CW-1:0] conflict_cnt
);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  owner_t        owner_q;
  owner_t        owner_d;
  logic          grant_a;
  logic          grant_b;
  logic          both_req;
  logic          rd_pend_a;
  logic          rd_pend_b;
  logic [DW-1:0] a_hold_p1;
  logic [DW-1:0] b_hold_p1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Arbitration state register: remembers which port owned the last access.
  // Reset to B so that A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_B;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    owner_d = owner_q;
    if (grant_a) begin
      owner_d = OWN_A;
    end else if (grant_b) begin
      owner_d = OWN_B;
    end
  end

  // Grants and RAM command (stage p0). Grants are held low during reset so no
  // access can reach the RAM while rst_n is asserted.
  always_comb begin
    both_req   = a_req & b_req;
    grant_a    = rst_n & a_req & (~b_req | (owner_q == OWN_B));
    grant_b    = rst_n & b_req & (~a_req | (owner_q == OWN_A));
    ram_we     = 1'b0;
    ram_rwaddr = '0;
    ram_di     = '0;
    if (grant_a) begin
      ram_we     = a_we;
      ram_rwaddr = a_addr;
      ram_di     = a_di;
    end else if (grant_b) begin
      ram_we     = b_we;
      ram_rwaddr = b_addr;
      ram_di     = b_di;
    end
  end

  assign a_gnt = grant_a;
  assign b_gnt = grant_b;

  // Read response tracking (stage p1): the pending flag marks the cycle in
  // which ram_do carries the data for that port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_a <= 1'b0;
      rd_pend_b <= 1'b0;
    end else begin
      rd_pend_a <= grant_a & ~a_we;
      rd_pend_b <= grant_b & ~b_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hold_p1 <= '0;
      b_hold_p1 <= '0;
    end else begin
      if (rd_pend_a) begin
        a_hold_p1 <= ram_do;
      end
      if (rd_pend_b) begin
        b_hold_p1 <= ram_do;
      end
    end
  end

  // The response cycle forwards ram_do directly so rvalid and data coincide;
  // afterwards the captured copy holds the value until the next response.
  assign a_rvalid = rd_pend_a;
  assign b_rvalid = rd_pend_b;
  assign a_do     = rd_pend_a ? ram_do : a_hold_p1;
  assign b_do     = rd_pend_b ? ram_do : b_hold_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (both_req) begin
      conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

endmodule
